// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: rotates an active-low row strobe, debounces presses and
// releases on scan ticks, and shifts each accepted key code into a 16-bit entry register.
module hex_keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col,
  input  logic        clear,
  output logic [3:0]  row,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] number,
  output logic [1:0]  state_dbg
);

  // key_valid is a one-cycle strobe with no ready/back-pressure; key_code and
  // number are already updated in the cycle key_valid is high.

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
  localparam bit FAST = (DEBOUNCE_SCANS <= 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t          state;
  logic [3:0]      col_meta;
  logic [3:0]      cs;
  logic [PW-1:0]   presc;
  logic            tick;
  logic [CW-1:0]   counter;
  logic [CW-1:0]   counter_next;
  logic            deb_done;
  logic [1:0]      r;
  logic [1:0]      r_next;
  logic [1:0]      c;
  logic [3:0]      accept_code;

  function automatic logic [1:0] lowest_zero(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  assign tick         = (presc == PW'(SCAN_DIV - 1));
  assign counter_next = counter + 1'b1;
  assign deb_done     = (counter_next == CW'(DEBOUNCE_SCANS));
  assign r_next       = r + 2'd1;
  // In SCAN the column comes straight from the sample (single-scan debounce);
  // afterwards it comes from the latched candidate.
  assign accept_code  = (state == SCAN) ? {r, lowest_zero(cs)} : {r, c};
  assign state_dbg    = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta <= 4'hF;
      cs       <= 4'hF;
    end else begin
      col_meta <= col;
      cs       <= col_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCAN;
      r         <= 2'd0;
      row       <= 4'b1110;
      presc     <= '0;
      counter   <= '0;
      c         <= 2'd0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      number    <= 16'h0000;
    end else begin
      key_valid <= 1'b0;
      presc     <= tick ? '0 : presc + 1'b1;
      if (clear) number <= 16'h0000;

      if (tick) begin
        unique case (state)
          SCAN: begin
            if (cs == 4'hF) begin
              r   <= r_next;
              row <= row_drive(r_next);
            end else begin
              c       <= lowest_zero(cs);
              counter <= CW'(1);
              if (FAST) begin
                key_code  <= accept_code;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                number    <= clear ? 16'h0000 : {number[11:0], accept_code};
                state     <= HELD;
              end else begin
                state <= DEBOUNCE;
              end
            end
          end

          DEBOUNCE: begin
            if (!cs[c]) begin
              counter <= counter_next;
              if (deb_done) begin
                key_code  <= accept_code;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                number    <= clear ? 16'h0000 : {number[11:0], accept_code};
                state     <= HELD;
              end
            end else begin
              counter <= '0;
              state   <= SCAN;
              r       <= r_next;
              row     <= row_drive(r_next);
            end
          end

          HELD: begin
            // Any other key on the fixed row is ignored until every column is released.
            if (cs == 4'hF) begin
              if (FAST) begin
                counter  <= '0;
                key_held <= 1'b0;
                state    <= SCAN;
                r        <= r_next;
                row      <= row_drive(r_next);
              end else begin
                counter <= CW'(1);
                state   <= RELEASE;
              end
            end
          end

          RELEASE: begin
            if (cs == 4'hF) begin
              if (deb_done) begin
                counter  <= '0;
                key_held <= 1'b0;
                state    <= SCAN;
                r        <= r_next;
                row      <= row_drive(r_next);
              end else begin
                counter <= counter_next;
              end
            end else begin
              state <= HELD;
            end
          end

          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Directed bench for hex_keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=2) with a
// row-aware keypad model driving col.
module tb_hex_keypad_scanner;

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] number;
  logic [1:0]  state_dbg;

  logic        pressed    = 1'b0;
  logic [1:0]  press_row  = 2'd0;
  logic [3:0]  press_mask = 4'hF;

  int checks      = 0;
  int errors      = 0;
  int valid_count = 0;
  int long_pulses = 0;
  logic kv_prev   = 1'b0;

  hex_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .col       (col),
    .clear     (clear),
    .row       (row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .number    (number),
    .state_dbg (state_dbg)
  );

  // clock/reset
  always #5 clk = ~clk;

  // Pressed key pulls its columns low only while its row is driven.
  assign col = (pressed && row == ~(4'b0001 << press_row)) ? press_mask : 4'hF;

  always @(posedge clk) begin
    if (key_valid) valid_count++;
    if (key_valid && kv_prev) long_pulses++;
    kv_prev = key_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input string tag, input logic [1:0] s, input int budget);
    int n = 0;
    while (state_dbg !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 16'(state_dbg), 16'(s));
  endtask

  task automatic wait_held_low(input string tag, input int budget);
    int n = 0;
    while (key_held !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 16'(key_held), 16'h0);
  endtask

  task automatic press_key(input logic [1:0] r, input logic [3:0] mask, input int hold,
                           output logic held_at_end);
    press_row  = r;
    press_mask = mask;
    pressed    = 1'b1;
    cycles(hold);
    held_at_end = key_held;
    pressed = 1'b0;
    wait_held_low("release_done", 60);
  endtask

  logic [3:0] idle_exp [4];
  logic [1:0] seq_row  [4];
  logic [3:0] seq_mask [4];
  logic       h;
  int         base;
  int         n;
  logic [3:0] old_row;

  initial begin
    idle_exp = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    seq_row  = '{2'd0, 2'd0, 2'd0, 2'd1};
    seq_mask = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    rst   = 1'b1;
    clear = 1'b0;
    cycles(3);
    rst = 1'b0;
    check("rst_row", 16'(row), 16'h000E);
    check("rst_key_code", 16'(key_code), 16'h0);
    check("rst_key_valid", 16'(key_valid), 16'h0);
    check("rst_key_held", 16'(key_held), 16'h0);
    check("rst_number", number, 16'h0000);
    check("rst_state", 16'(state_dbg), 16'(ST_SCAN));

    // Idle rotation, one row step per 4 cycles
    for (int i = 0; i < 4; i++) begin
      old_row = row;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (row == old_row && n < 8);
      check("idle_row", 16'(row), 16'(idle_exp[i]));
      check("idle_period", 16'(n), 16'd4);
    end
    check("idle_no_valid", 16'(valid_count), 16'd0);

    // Row 2 / col 1 -> key 9
    base = valid_count;
    press_key(2'd2, 4'b1101, 40, h);
    check("k9_pulses", 16'(valid_count - base), 16'd1);
    check("k9_code", 16'(key_code), 16'h9);
    check("k9_number", number, 16'h0009);
    check("k9_held_while_down", 16'(h), 16'h1);

    // Keys 1,2,3,4 then F
    base = valid_count;
    for (int i = 0; i < 4; i++) press_key(seq_row[i], seq_mask[i], 40, h);
    check("seq_pulses", 16'(valid_count - base), 16'd4);
    check("seq_number", number, 16'h1234);
    press_key(2'd3, 4'b0111, 40, h);
    check("kf_code", 16'(key_code), 16'hF);
    check("kf_number", number, 16'h234F);

    // One-tick bounce on row 0 col 0
    base = valid_count;
    n = 0;
    while (row == 4'b1110 && n < 40) begin
      @(negedge clk);
      n++;
    end
    while (row != 4'b1110 && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("bounce_sync", 16'(row), 16'h000E);
    press_row  = 2'd0;
    press_mask = 4'b1110;
    pressed    = 1'b1;
    cycles(4);
    check("bounce_in_debounce", 16'(state_dbg), 16'(ST_DEBOUNCE));
    check("bounce_row_fixed", 16'(row), 16'h000E);
    pressed = 1'b0;
    cycles(4);
    check("bounce_state", 16'(state_dbg), 16'(ST_SCAN));
    check("bounce_resume_row", 16'(row), 16'h000D);
    check("bounce_no_valid", 16'(valid_count - base), 16'd0);

    // Two columns on row 0 -> lowest column; release glitch back to HELD
    base = valid_count;
    press_row  = 2'd0;
    press_mask = 4'b1010;
    pressed    = 1'b1;
    wait_state("multi_held", ST_HELD, 40);
    check("multi_code", 16'(key_code), 16'h0);
    check("multi_key_held", 16'(key_held), 16'h1);
    pressed = 1'b0;
    wait_state("glitch_release", ST_RELEASE, 20);
    pressed = 1'b1;
    cycles(4);
    check("glitch_back_held", 16'(state_dbg), 16'(ST_HELD));
    check("glitch_key_held", 16'(key_held), 16'h1);
    cycles(8);
    pressed = 1'b0;
    wait_held_low("multi_release", 40);
    check("glitch_one_pulse", 16'(valid_count - base), 16'd1);
    check("multi_number", number, 16'h34F0);

    // Plain clear
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
    check("clear_number", number, 16'h0000);

    // Clear coincident with accept of key 6
    press_key(2'd2, 4'b1011, 40, h);
    check("ka_number", number, 16'h000A);
    press_row  = 2'd1;
    press_mask = 4'b1011;
    pressed    = 1'b1;
    wait_state("clr_acc_debounce", ST_DEBOUNCE, 40);
    cycles(3);
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
    check("clr_acc_valid", 16'(key_valid), 16'h1);
    check("clr_acc_code", 16'(key_code), 16'h6);
    check("clr_acc_number", number, 16'h0000);
    pressed = 1'b0;
    wait_held_low("clr_acc_release", 60);

    // Reset in DEBOUNCE with the key still down
    press_key(2'd2, 4'b1011, 40, h);
    press_row  = 2'd3;
    press_mask = 4'b1101;
    pressed    = 1'b1;
    wait_state("rst_mid_debounce", ST_DEBOUNCE, 40);
    base = valid_count;
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check("rst2_row", 16'(row), 16'h000E);
    check("rst2_state", 16'(state_dbg), 16'(ST_SCAN));
    check("rst2_key_code", 16'(key_code), 16'h0);
    check("rst2_key_valid", 16'(key_valid), 16'h0);
    check("rst2_key_held", 16'(key_held), 16'h0);
    check("rst2_number", number, 16'h0000);
    cycles(2);
    check("rst2_no_valid", 16'(valid_count - base), 16'd0);
    pressed = 1'b0;
    cycles(20);

    check("pulse_width_one", 16'(long_pulses), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hex_keypad_scanner.md
HEX_KEYPAD_SCANNER -- requirements
Module: hex_keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clock cycles per scan tick.
REQ-002 Parameter DEBOUNCE_SCANS, default 4: consecutive stable ticks required for press and for release.
REQ-003 clk  input  1  sole clock; all logic on posedge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 col  input  4  keypad column sense; active-low; asynchronous to clk; externally pulled up.
REQ-006 clear  input  1  synchronous; when high, zeroes number.
REQ-007 row  output  4  keypad row drive; active-low, one-hot low.
REQ-008 key_code  output  4  hex code of the last accepted key.
REQ-009 key_valid  output  1  one-cycle pulse per accepted key press.
REQ-010 key_held  output  1  high while an accepted key is still down.
REQ-011 number  output  16  hex entry register, fed by accepted keys; drives a 7-seg number port.

Function
REQ-012 col shall pass through a 2-flop synchronizer; all logic uses only the synchronized value cs.
REQ-013 Prescaler counts 0..SCAN_DIV-1 and wraps; tick is high for one cycle when prescaler == SCAN_DIV-1.
REQ-014 FSM states: SCAN, DEBOUNCE, HELD, RELEASE; state changes and samples of cs occur only on tick cycles, except key_valid deassertion.
REQ-015 Row index r (0..3) drives row = ~(1<<r); r0 -> 4'b1110, r3 -> 4'b0111.
REQ-016 SCAN, tick, cs == 4'b1111: r <= r+1 (wraps 3->0); stay in SCAN.
REQ-017 SCAN, tick, cs != 4'b1111: latch r and c = lowest index with cs[c]==0; counter <= 1; go DEBOUNCE; r unchanged.
REQ-018 DEBOUNCE, tick, cs[c]==0: counter++; when counter reaches DEBOUNCE_SCANS, accept key and go HELD.
REQ-019 DEBOUNCE, tick, cs[c]==1: discard candidate; counter <= 0; go SCAN and advance r.
REQ-020 Accept: key_code <= {r[1:0], c[1:0]} (r*4+c); key_valid high for exactly the following cycle; number <= {number[11:0], code}; key_held <= 1.
REQ-021 HELD, tick, cs == 4'b1111: counter <= 1; go RELEASE. Otherwise stay in HELD; other keys are ignored.
REQ-022 RELEASE, tick, cs == 4'b1111: counter++; at DEBOUNCE_SCANS, key_held <= 0, go SCAN, advance r.
REQ-023 RELEASE, tick, cs != 4'b1111: return to HELD with no new key_valid.
REQ-024 For DEBOUNCE_SCANS == 1, acceptance occurs on the tick that enters DEBOUNCE; release completes on the tick that enters RELEASE.
REQ-025 clear has priority over the shift: clear and accept in the same cycle -> number = 0; key_valid and key_code still update.
REQ-026 Row stays fixed from the press candidate until release completes; only one key is reported per press.
REQ-027 Latency from a stable col low on the driven row to key_valid is at most (2 + DEBOUNCE_SCANS) ticks + 3 cycles.

Reset
REQ-028 rst shall set state = SCAN, r = 0, row = 4'b1110, prescaler = 0, counter = 0, key_code = 0, key_valid = 0, key_held = 0, number = 16'h0000, and synchronizer flops = 4'b1111.
REQ-029 rst shall take priority over clear and tick in every state; reset mid-press returns to SCAN with no key_valid, even if the key is still held.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=2)
REQ-030 Idle, col=4'b1111 -> row rotates 1110,1101,1011,0111,1110 every 4 cycles; key_valid stays 0.
REQ-031 Press row2/col1 (col[1]=0 when row==4'b1011), hold 40 cycles -> one key_valid pulse; key_code=4'h9; number=16'h0009; key_held=1 until release debounced.
REQ-032 Keys 1,2,3,4 pressed and released in turn -> number=16'h1234. A fifth key F -> number=16'h234F.
REQ-033 Bounce: col[0] low for one tick then high on row0 -> no key_valid; scan resumes at row1.
REQ-034 Row0, col=4'b1010 held -> key_code=4'h0 (lowest column). Release glitch of one tick during RELEASE -> back to HELD, no second pulse.
REQ-035 clear asserted on the accept cycle -> number=0, key_valid=1; rst mid-DEBOUNCE -> all outputs at reset values, row=4'b1110.
